trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: ret_valid  in  1  one instruction retires this cycle; pc  in  16  its PC.
REQ-005 SHALL have ports: reg_write  in  1; wr_reg  in  4; wr_data  in  16  register writeback of the retiring instruction.
REQ-006 SHALL have ports: mem_read  in  1; mem_write  in  1; mem_addr  in  16; mem_data  in  16  data-memory access of the retiring instruction.
REQ-007 SHALL have ports: hlt  in  1  retiring instruction is HLT.
REQ-008 SHALL have ports: rec_valid  out  1; rec_ready  in  1  valid/ready record handshake.
REQ-009 SHALL have ports: rec_kind  out  3; rec_inum  out  16; rec_pc  out  16; rec_reg  out  4; rec_value  out  16; rec_addr  out  16  head record fields.
REQ-010 SHALL have ports: overflow  out  1  sticky drop flag; drop_cnt  out  8  saturating dropped-record count; done  out  1  halt record consumed.

Function
REQ-011 SHALL classify each retirement by priority: hlt -> HALT(4); reg_write & mem_read -> LOAD(1); reg_write -> REG(0); mem_write -> STORE(2); otherwise -> OTHER(3).
REQ-012 SHALL fill fields: REG/LOAD rec_reg=wr_reg, rec_value=wr_data; LOAD rec_addr=mem_addr; STORE rec_addr=mem_addr, rec_value=mem_data; unused fields zero.
REQ-013 SHALL assign rec_inum from a 16-bit counter starting at 0, incremented once per retirement (dropped ones included), wrapping 0xFFFF -> 0x0000.
REQ-014 SHALL push a record on the rising edge where ret_valid=1 in state CAPTURE; rec_valid SHALL rise on the following cycle when the FIFO was empty (1-cycle latency).
REQ-015 SHALL pop the head on a rising edge where rec_valid & rec_ready; head fields SHALL remain stable while rec_valid & ~rec_ready.
REQ-016 SHALL accept a push on the same edge as a pop when the FIFO is full.
REQ-017 SHALL, when full without a same-edge pop, drop a non-HALT record, set overflow, and increment drop_cnt, saturating at 0xFF.
REQ-018 SHALL never drop a HALT record: when full, HALT is held in a one-entry pending slot and enqueued on the first edge with space.
REQ-019 SHALL implement FSM CAPTURE -> HALTED (on a HALT retirement) -> DONE (when the HALT record pops); DONE is terminal until reset.
REQ-020 SHALL ignore ret_valid in HALTED and DONE; inum SHALL not advance there.
REQ-021 SHALL assert done only in DONE; rec_valid SHALL be 0 in DONE.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously clear the FIFO pointers, pending slot, inum, drop_cnt, overflow, and done, and enter CAPTURE.
REQ-023 SHALL drive rec_valid=0 and all rec_* fields 0 during reset.
REQ-024 SHALL discard all queued records on reset asserted mid-operation; no partial record SHALL survive.

Configuration
REQ-025 SHALL, with TRACE_CYCLE_STAMP_EN defined, add output rec_cycle (32 bits) carrying a free-running cycle count captured at push, cleared by reset, counting from 1 on the first edge after reset release.
REQ-026 SHALL, without TRACE_CYCLE_STAMP_EN, omit the rec_cycle port and counter, with all other behaviour identical.

Structure
REQ-027 SHALL place the rec_kind encodings (REG, LOAD, STORE, OTHER, HALT), the record struct, and FSM state encodings in shared package trace_pkg.
REQ-028 SHALL implement storage in sub-module trace_fifo (parameter DEPTH; push, pop, full, empty, and head data).

Verification
REQ-029 SHALL cover: retire pc=0x0000, reg_write, wr_reg=3, wr_data=0x0005, rec_ready=1 -> next cycle rec_valid=1, kind=0, inum=0, reg=3, value=0x0005.
REQ-030 SHALL cover: load pc=0x0002, wr_reg=1, wr_data=0xBEEF, mem_addr=0x0010, then store mem_addr=0x0020, mem_data=0x1234 -> kind 1 then kind 2 with those fields and inum 0 then 1.
REQ-031 SHALL cover: DEPTH=8, rec_ready=0, 10 retirements -> 8 queued, overflow=1, drop_cnt=2; draining shows inum 0..7.
REQ-032 SHALL cover: FIFO full, rec_ready=0, hlt at pc=0x0040 -> record held; one pop frees a slot and HALT is enqueued; after drain done=1; later ret_valid pulses are ignored.
REQ-033 SHALL cover: full FIFO with simultaneous pop and push -> count stays 8 and overflow stays 0.
REQ-034 SHALL cover: rst_n asserted with 5 queued records -> rec_valid=0 immediately; after release the next record has inum=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace capture block: record kinds, record layout, FSM states.
// The record carries a cycle stamp only when TRACE_CYCLE_STAMP_EN is defined.
package trace_pkg;

   typedef enum logic [2:0] {
      KIND_REG   = 3'd0,
      KIND_LOAD  = 3'd1,
      KIND_STORE = 3'd2,
      KIND_OTHER = 3'd3,
      KIND_HALT  = 3'd4
   } recKind_t;

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_HALTED  = 2'd1,
      ST_DONE    = 2'd2
   } capState_t;

   typedef struct packed {
      recKind_t    kind;
      logic [15:0] inum;
      logic [15:0] pc;
      logic [3:0]  regIdx;
      logic [15:0] value;
      logic [15:0] addr;
`ifdef TRACE_CYCLE_STAMP_EN
      logic [31:0] cycle;
`endif
   } traceRec_t;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   // Classify one retirement by priority and fill only the fields its kind uses.
   function automatic traceRec_t buildRec(
      input logic        hlt,
      input logic        regWrite,
      input logic        memRead,
      input logic        memWrite,
      input logic [3:0]  wrReg,
      input logic [15:0] wrData,
      input logic [15:0] memAddr,
      input logic [15:0] memData,
      input logic [15:0] pc,
      input logic [15:0] inum
   );
      traceRec_t rec;
      rec      = '0;
      rec.inum = inum;
      rec.pc   = pc;
      if (hlt) begin
         rec.kind = KIND_HALT;
      end else if (regWrite && memRead) begin
         rec.kind   = KIND_LOAD;
         rec.regIdx = wrReg;
         rec.value  = wrData;
         rec.addr   = memAddr;
      end else if (regWrite) begin
         rec.kind   = KIND_REG;
         rec.regIdx = wrReg;
         rec.value  = wrData;
      end else if (memWrite) begin
         rec.kind  = KIND_STORE;
         rec.addr  = memAddr;
         rec.value = memData;
      end else begin
         rec.kind = KIND_OTHER;
      end
      return rec;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record storage for trace_capture: DEPTH-entry FIFO, accepts a push on a full edge
// only together with a pop. Storage is not reset; only pointers and occupancy are.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  traceRec_t pushData,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output traceRec_t headData
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   traceRec_t     mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   count;
   logic          pushOk;
   logic          popOk;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign popOk    = pop & ~empty;
   assign pushOk   = push & (~full | popOk);
   assign headData = mem[rdPtr];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) begin
            wrPtr <= wrPtr + PTR_ONE;
         end
         if (popOk) begin
            rdPtr <= rdPtr + PTR_ONE;
         end
         case ({pushOk, popOk})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Record storage write port.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem[wrPtr] <= pushData;
      end
   end

endmodule

// File: rtl/trace_capture.sv
// Retirement trace capture: classifies retiring instructions into records and queues them
// for a valid/ready consumer. Optional TRACE_CYCLE_STAMP_EN adds a 32-bit rec_cycle stamp.
module trace_capture
   import trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ret_valid,
   input  logic [15:0] pc,
   input  logic        reg_write,
   input  logic [3:0]  wr_reg,
   input  logic [15:0] wr_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        hlt,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [2:0]  rec_kind,
   output logic [15:0] rec_inum,
   output logic [15:0] rec_pc,
   output logic [3:0]  rec_reg,
   output logic [15:0] rec_value,
   output logic [15:0] rec_addr,
`ifdef TRACE_CYCLE_STAMP_EN
   output logic [31:0] rec_cycle,
`endif
   output logic        overflow,
   output logic [7:0]  drop_cnt,
   output logic        done
);

   capState_t   state;
   capState_t   stateNxt;
   logic [15:0] inum;
   logic [7:0]  dropCnt;
   logic        overflowR;
   logic        doneR;
   logic        pendValid;
   traceRec_t   pendRec;
   traceRec_t   newRec;
   traceRec_t   pushData;
   traceRec_t   headRec;
   logic        fifoFull;
   logic        fifoEmpty;
   logic        retAcc;
   logic        recValid;
   logic        popS;
   logic        space;
   logic        pushS;
   logic        loadPend;
   logic        dropS;
`ifdef TRACE_CYCLE_STAMP_EN
   logic [31:0] cycleCnt;
`endif

   assign retAcc   = ret_valid & (state == ST_CAPTURE);
   assign recValid = ~fifoEmpty & (state != ST_DONE);
   assign popS     = recValid & rec_ready;
   assign space    = ~fifoFull | popS;

   // Build the candidate record for this cycle's retirement.
   always_comb begin
      newRec = buildRec(hlt, reg_write, mem_read, mem_write, wr_reg, wr_data,
                        mem_addr, mem_data, pc, inum);
`ifdef TRACE_CYCLE_STAMP_EN
      newRec.cycle = cycleCnt + 32'd1;
`endif
   end

   trace_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (pushS),
      .pushData (pushData),
      .pop      (popS),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .headData (headRec)
   );

   // Next state plus push/hold/drop decision; a held HALT always wins the next free slot.
   always_comb begin
      stateNxt = state;
      pushS    = 1'b0;
      pushData = newRec;
      loadPend = 1'b0;
      dropS    = 1'b0;
      if (pendValid) begin
         pushData = pendRec;
         if (space) begin
            pushS = 1'b1;
         end else begin
            pushS = 1'b0;
         end
      end else if (retAcc) begin
         if (space) begin
            pushS = 1'b1;
         end else if (newRec.kind == KIND_HALT) begin
            loadPend = 1'b1;
         end else begin
            dropS = 1'b1;
         end
      end else begin
         pushS = 1'b0;
      end
      case (state)
         ST_CAPTURE: begin
            if (retAcc && hlt) begin
               stateNxt = ST_HALTED;
            end else begin
               stateNxt = ST_CAPTURE;
            end
         end
         ST_HALTED: begin
            if (popS && (headRec.kind == KIND_HALT)) begin
               stateNxt = ST_DONE;
            end else begin
               stateNxt = ST_HALTED;
            end
         end
         ST_DONE:  stateNxt = ST_DONE;
         default:  stateNxt = ST_CAPTURE;
      endcase
   end

   // State, instruction numbering, pending HALT slot and drop statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_CAPTURE;
         inum      <= 16'd0;
         dropCnt   <= 8'd0;
         overflowR <= 1'b0;
         doneR     <= 1'b0;
         pendValid <= 1'b0;
         pendRec   <= '0;
      end else begin
         state <= stateNxt;
         doneR <= (stateNxt == ST_DONE);
         if (retAcc) begin
            inum <= inum + 16'd1;
         end
         if (loadPend) begin
            pendValid <= 1'b1;
            pendRec   <= newRec;
         end else if (pendValid && space) begin
            pendValid <= 1'b0;
         end
         if (dropS) begin
            overflowR <= 1'b1;
            if (dropCnt != DROP_MAX) begin
               dropCnt <= dropCnt + 8'd1;
            end
         end
      end
   end

`ifdef TRACE_CYCLE_STAMP_EN
   // Free-running cycle counter; reads 1 after the first edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt <= 32'd0;
      end else begin
         cycleCnt <= cycleCnt + 32'd1;
      end
   end

   assign rec_cycle = recValid ? headRec.cycle : 32'd0;
`endif

   // Fields read as zero whenever no record is offered, so stale storage never leaks out.
   assign rec_valid = recValid;
   assign rec_kind  = recValid ? headRec.kind   : 3'd0;
   assign rec_inum  = recValid ? headRec.inum   : 16'd0;
   assign rec_pc    = recValid ? headRec.pc     : 16'd0;
   assign rec_reg   = recValid ? headRec.regIdx : 4'd0;
   assign rec_value = recValid ? headRec.value  : 16'd0;
   assign rec_addr  = recValid ? headRec.addr   : 16'd0;
   assign overflow  = overflowR;
   assign drop_cnt  = dropCnt;
   assign done      = doneR;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: expected records are queued when a retirement is
// driven and compared against the head whenever the DUT offers a record.
module tb_trace_capture;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ret_valid, reg_write, mem_read, mem_write, hlt, rec_ready;
   logic [15:0] pc, wr_data, mem_addr, mem_data;
   logic [3:0]  wr_reg;
   logic        rec_valid, overflow, done;
   logic [2:0]  rec_kind;
   logic [15:0] rec_inum, rec_pc, rec_value, rec_addr;
   logic [3:0]  rec_reg;
   logic [7:0]  drop_cnt;
`ifdef TRACE_CYCLE_STAMP_EN
   logic [31:0] rec_cycle;
`endif

   always #5 clk = ~clk;

   trace_capture #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .pc(pc),
      .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
      .hlt(hlt), .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_kind(rec_kind), .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg),
      .rec_value(rec_value), .rec_addr(rec_addr),
`ifdef TRACE_CYCLE_STAMP_EN
      .rec_cycle(rec_cycle),
`endif
      .overflow(overflow), .drop_cnt(drop_cnt), .done(done)
   );

   typedef struct {
      logic [2:0]  kind;
      logic [15:0] inum;
      logic [15:0] pc;
      logic [3:0]  rg;
      logic [15:0] value;
      logic [15:0] addr;
   } expRec_t;

   expRec_t     expQ[$];
   expRec_t     mPend;
   bit          mPendValid;
   int          mState;
   logic [15:0] mInum;
   int          mDrop;
   int          nChecks = 0;
   int          nFails  = 0;

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clearModel();
      expQ.delete();
      mPendValid = 1'b0;
      mState     = 0;
      mInum      = 16'd0;
      mDrop      = 0;
   endtask

   task automatic idle();
      ret_valid = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hlt = 1'b0;
      pc = 16'd0; wr_reg = 4'd0; wr_data = 16'd0; mem_addr = 16'd0; mem_data = 16'd0;
   endtask

   task automatic driveRet(input logic h, input logic rw, input logic mr, input logic mw,
                           input logic [3:0] wr, input logic [15:0] wd, input logic [15:0] ma,
                           input logic [15:0] md, input logic [15:0] p);
      ret_valid = 1'b1; hlt = h; reg_write = rw; mem_read = mr; mem_write = mw;
      wr_reg = wr; wr_data = wd; mem_addr = ma; mem_data = md; pc = p;
   endtask

   // Expected record for the retirement currently on the inputs.
   function automatic expRec_t mkRec();
      expRec_t r;
      r.kind = 3'd3; r.inum = mInum; r.pc = pc; r.rg = 4'd0; r.value = 16'd0; r.addr = 16'd0;
      if (hlt) begin
         r.kind = 3'd4;
      end else if (reg_write && mem_read) begin
         r.kind = 3'd1; r.rg = wr_reg; r.value = wr_data; r.addr = mem_addr;
      end else if (reg_write) begin
         r.kind = 3'd0; r.rg = wr_reg; r.value = wr_data;
      end else if (mem_write) begin
         r.kind = 3'd2; r.addr = mem_addr; r.value = mem_data;
      end
      return r;
   endfunction

   // One clock: check the offered head, advance the model, then cross the rising edge.
   task automatic tick();
      expRec_t e;
      expRec_t r;
      bit      expVis;
      bit      popNow;
      expVis = (expQ.size() > 0) && (mState != 2);
      checkVal("rec_valid", 32'(rec_valid), 32'(expVis));
      popNow = expVis && rec_ready;
      if (expVis) begin
         e = expQ[0];
         checkVal("kind",  32'(rec_kind),  32'(e.kind));
         checkVal("inum",  32'(rec_inum),  32'(e.inum));
         checkVal("pc",    32'(rec_pc),    32'(e.pc));
         checkVal("reg",   32'(rec_reg),   32'(e.rg));
         checkVal("value", 32'(rec_value), 32'(e.value));
         checkVal("addr",  32'(rec_addr),  32'(e.addr));
         if (popNow) begin
            void'(expQ.pop_front());
            if (e.kind == 3'd4) mState = 2;
         end
      end
      if (mPendValid) begin
         if (expQ.size() < DEPTH) begin
            expQ.push_back(mPend);
            mPendValid = 1'b0;
         end
      end else if (ret_valid && mState == 0) begin
         r = mkRec();
         mInum = mInum + 16'd1;
         if (expQ.size() < DEPTH) begin
            expQ.push_back(r);
         end else if (r.kind == 3'd4) begin
            mPend = r;
            mPendValid = 1'b1;
         end else begin
            if (mDrop < 255) mDrop++;
         end
         if (hlt) mState = 1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      idle();
      rec_ready = 1'b1;
      n = 0;
      while ((expQ.size() > 0 || mPendValid) && n < 40) begin
         tick();
         n++;
      end
      if (expQ.size() > 0 || mPendValid) checkVal("drain_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // Reset asserted between edges; outputs must clear immediately.
   task automatic applyReset();
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("rst_rec_valid", 32'(rec_valid), 32'd0);
      checkVal("rst_rec_kind",  32'(rec_kind),  32'd0);
      checkVal("rst_rec_inum",  32'(rec_inum),  32'd0);
      checkVal("rst_rec_value", 32'(rec_value), 32'd0);
      checkVal("rst_overflow",  32'(overflow),  32'd0);
      checkVal("rst_drop_cnt",  32'(drop_cnt),  32'd0);
      checkVal("rst_done",      32'(done),      32'd0);
      clearModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rec_ready = 1'b0;
      rst_n     = 1'b1;
      clearModel();
      @(negedge clk);
      applyReset();

      // Single register write, consumer always ready.
      rec_ready = 1'b1;
      driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0005, 16'h0000, 16'h0000, 16'h0000);
      tick();
      idle();
      checkVal("first_valid", 32'(rec_valid), 32'd1);
      drain();

      // Load then store.
      applyReset();
      rec_ready = 1'b1;
      driveRet(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'hBEEF, 16'h0010, 16'h0000, 16'h0002);
      tick();
      driveRet(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0020, 16'h1234, 16'h0004);
      tick();
      drain();

      // Overflow: ten retirements into an eight-entry FIFO that is not drained.
      applyReset();
      rec_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 16'h0100 + 16'(i), 16'h0000, 16'h0000, 16'(i * 2));
         tick();
      end
      idle();
      tick();
      checkVal("ovf_overflow", 32'(overflow), 32'd1);
      checkVal("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
      drain();
      checkVal("ovf_drained_inum_next", 32'(mInum), 32'd10);

      // Full FIFO with simultaneous pop and push keeps occupancy at eight.
      applyReset();
      rec_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         driveRet(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0200 + 16'(i), 16'hA000 + 16'(i), 16'(i));
         tick();
      end
      rec_ready = 1'b1;
      driveRet(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0080);
      tick();
      rec_ready = 1'b0;
      idle();
      tick();
      checkVal("popush_overflow", 32'(overflow), 32'd0);
      checkVal("popush_drop_cnt", 32'(drop_cnt), 32'd0);
      driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 16'h0999, 16'h0000, 16'h0000, 16'h0090);
      tick();
      idle();
      tick();
      checkVal("popush_full_drop", 32'(drop_cnt), 32'd1);
      drain();

      // HALT arriving at a full FIFO is held, then enqueued once a slot frees.
      applyReset();
      rec_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         driveRet(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0020 + 16'(i));
         tick();
      end
      driveRet(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0040);
      tick();
      driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h7777, 16'h0000, 16'h0000, 16'h0042);
      tick();
      idle();
      checkVal("halt_overflow", 32'(overflow), 32'd0);
      checkVal("halt_done_early", 32'(done), 32'd0);
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      tick();
      drain();
      checkVal("halt_done", 32'(done), 32'd1);
      for (int i = 0; i < 3; i++) begin
         driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0055, 16'h0000, 16'h0000, 16'h0050);
         tick();
      end
      idle();
      tick();
      checkVal("halt_done_stays", 32'(done), 32'd1);
      checkVal("halt_overflow_end", 32'(overflow), 32'd0);

      // Reset with queued records discards them; numbering restarts at zero.
      applyReset();
      rec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0400 + 16'(i), 16'h0000, 16'h0000, 16'h0100 + 16'(i));
         tick();
      end
      idle();
      checkVal("pre_rst_valid", 32'(rec_valid), 32'd1);
      applyReset();
      rec_ready = 1'b1;
      driveRet(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 16'h00AA, 16'h0000, 16'h0000, 16'h0200);
      tick();
      idle();
      checkVal("post_rst_inum", 32'(rec_inum), 32'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
